// File: rtl/rc4_sched_if.sv
// rc4_sched_if: groups the RC4 scheduler's control handshakes, task-side
// S-memory request ports and the arbitrated S-memory bus.
// slave  = the scheduler (rc4_sched)
// master = the surrounding top level / task modules
interface rc4_sched_if #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [KEY_W-1:0]  key_in;
    logic              rdy;
    logic              done;
    logic              key_found;
    logic [KEY_W-1:0]  key_out;

    logic              init_en,  ksa_en,  prga_en;
    logic              init_rdy, ksa_rdy, prga_rdy;
    logic              chk_valid;

    logic [ADDR_W-1:0] init_addr,   ksa_addr,   prga_addr;
    logic [7:0]        init_wrdata, ksa_wrdata, prga_wrdata;
    logic              init_wren,   ksa_wren,   prga_wren;

    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_wrdata;
    logic              s_wren;

    modport slave (
        input  start, key_in,
        input  init_rdy, ksa_rdy, prga_rdy, chk_valid,
        input  init_addr, ksa_addr, prga_addr,
        input  init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, done, key_found, key_out,
        output init_en, ksa_en, prga_en,
        output s_addr, s_wrdata, s_wren
    );

    modport master (
        output start, key_in,
        output init_rdy, ksa_rdy, prga_rdy, chk_valid,
        output init_addr, ksa_addr, prga_addr,
        output init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, done, key_found, key_out,
        input  init_en, ksa_en, prga_en,
        input  s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/rc4_sched.sv
// rc4_sched: sequences the RC4 init -> KSA -> PRGA tasks through their
// rdy/en handshakes and grants the single-port S memory to the active task.
// Optional feature macro: RC4_CRACK_EN -- when defined, a failed check
// increments the key and reruns all three tasks until a valid plaintext is
// seen or the key reaches its maximum value (no wrap).
module rc4_sched #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    rc4_sched_if.slave  bus
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] INIT_GO   = 4'd1;
    localparam logic [3:0] INIT_WAIT = 4'd2;
    localparam logic [3:0] KSA_GO    = 4'd3;
    localparam logic [3:0] KSA_WAIT  = 4'd4;
    localparam logic [3:0] PRGA_GO   = 4'd5;
    localparam logic [3:0] PRGA_WAIT = 4'd6;
    localparam logic [3:0] CHECK     = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INIT = 2'd1;
    localparam logic [1:0] OWN_KSA  = 2'd2;
    localparam logic [1:0] OWN_PRGA = 2'd3;

`ifdef RC4_CRACK_EN
    localparam logic [KEY_W-1:0] KEY_MAX = '1;
`endif

    logic [3:0]       state;
    logic             wait_armed;   // set after the first WAIT cycle
    logic [1:0]       owner;
    logic [KEY_W-1:0] key_q;
    logic             done_q;
    logic             found_q;

    assign bus.rdy       = (state == IDLE) || (state == DONE);
    assign bus.done      = done_q;
    assign bus.key_found = found_q;
    assign bus.key_out   = key_q;

    // Task start pulses: asserted only in the GO state while the task is idle
    assign bus.init_en = (state == INIT_GO) && bus.init_rdy;
    assign bus.ksa_en  = (state == KSA_GO)  && bus.ksa_rdy;
    assign bus.prga_en = (state == PRGA_GO) && bus.prga_rdy;

    // Phase FSM; owner is updated alongside each transition so it always
    // matches the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_armed <= 1'b0;
            owner      <= OWN_NONE;
            key_q      <= '0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        key_q   <= bus.key_in;
                        done_q  <= 1'b0;
                        found_q <= 1'b0;
                        state   <= INIT_GO;
                        owner   <= OWN_INIT;
                    end
                end
                INIT_GO: begin
                    wait_armed <= 1'b0;
                    if (bus.init_rdy) state <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (!wait_armed) begin
                        wait_armed <= 1'b1;
                    end else if (bus.init_rdy) begin
                        state <= KSA_GO;
                        owner <= OWN_KSA;
                    end
                end
                KSA_GO: begin
                    wait_armed <= 1'b0;
                    if (bus.ksa_rdy) state <= KSA_WAIT;
                end
                KSA_WAIT: begin
                    if (!wait_armed) begin
                        wait_armed <= 1'b1;
                    end else if (bus.ksa_rdy) begin
                        state <= PRGA_GO;
                        owner <= OWN_PRGA;
                    end
                end
                PRGA_GO: begin
                    wait_armed <= 1'b0;
                    if (bus.prga_rdy) state <= PRGA_WAIT;
                end
                PRGA_WAIT: begin
                    if (!wait_armed) begin
                        wait_armed <= 1'b1;
                    end else if (bus.prga_rdy) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
`ifdef RC4_CRACK_EN
                    if (bus.chk_valid) begin
                        found_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= DONE;
                        owner   <= OWN_NONE;
                    end else if (key_q == KEY_MAX) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                        owner   <= OWN_NONE;
                    end else begin
                        key_q <= key_q + 1'b1;
                        state <= INIT_GO;
                        owner <= OWN_INIT;
                    end
`else
                    found_q <= bus.chk_valid;
                    done_q  <= 1'b1;
                    state   <= DONE;
                    owner   <= OWN_NONE;
`endif
                end
                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // S-memory mux: forwards only the owning task's port, zeros otherwise
    always_comb begin
        bus.s_addr   = '0;
        bus.s_wrdata = '0;
        bus.s_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                bus.s_addr   = bus.init_addr;
                bus.s_wrdata = bus.init_wrdata;
                bus.s_wren   = bus.init_wren;
            end
            OWN_KSA: begin
                bus.s_addr   = bus.ksa_addr;
                bus.s_wrdata = bus.ksa_wrdata;
                bus.s_wren   = bus.ksa_wren;
            end
            OWN_PRGA: begin
                bus.s_addr   = bus.prga_addr;
                bus.s_wrdata = bus.prga_wrdata;
                bus.s_wren   = bus.prga_wren;
            end
            default: ;
        endcase
    end

endmodule
